// File: rtl/ts_pkg.sv
// Shared defaults for the trigger conditioner.
//   NChDefault      - default channel count
//   FilterWDefault  - default glitch-filter counter width
//   HoldoffWDefault - default holdoff counter width
//   StartupCnt      - cycles after reset during which f loads s and edges are masked
package ts_pkg;

  localparam int unsigned NChDefault      = 8;
  localparam int unsigned FilterWDefault  = 8;
  localparam int unsigned HoldoffWDefault = 16;

  localparam logic [1:0]  StartupCnt      = 2'd3;

endpackage

// File: rtl/ts_trig_chan.sv
// One trigger channel: 2-FF synchroniser, glitch filter, edge select and holdoff.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   pin           - raw asynchronous trigger pin
//   startup       - high while the top's startup counter runs; f tracks s, no edges
//   enable        - channel enable
//   rise_en       - accept rising edges
//   fall_en       - accept falling edges
//   filter_len    - extra stable cycles required before f follows s
//   holdoff       - dead time loaded after an accepted edge
//   accepted      - combinational: an edge is accepted this cycle
module ts_trig_chan
  import ts_pkg::*;
#(
  parameter int unsigned FILTER_W  = FilterWDefault,
  parameter int unsigned HOLDOFF_W = HoldoffWDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pin,
  input  logic                 startup,
  input  logic                 enable,
  input  logic                 rise_en,
  input  logic                 fall_en,
  input  logic [FILTER_W-1:0]  filter_len,
  input  logic [HOLDOFF_W-1:0] holdoff,
  output logic                 accepted
);

  logic                 sync1_q, s_q;
  logic                 f_q, f_d;
  logic                 f_dly_q, f_dly_d;
  logic [FILTER_W-1:0]  c_q, c_d;
  logic [HOLDOFF_W-1:0] h_q, h_d;
  logic                 rise, fall, hit;

  always_comb begin
    f_d     = f_q;
    f_dly_d = f_q;
    c_d     = '0;
    if (startup) begin
      // Loading the delay stage too keeps a pin held high through reset from
      // looking like a rising edge once startup ends.
      f_d     = s_q;
      f_dly_d = s_q;
    end else if (s_q != f_q) begin
      if (c_q >= filter_len) begin
        f_d = s_q;
      end else begin
        c_d = c_q + 1'b1;
      end
    end

    rise     = f_q & ~f_dly_q;
    fall     = ~f_q & f_dly_q;
    hit      = ~startup & enable & ((rise & rise_en) | (fall & fall_en));
    accepted = hit && (h_q == '0);

    // Holdoff keeps counting regardless of enable.
    h_d = h_q;
    if (accepted) begin
      h_d = holdoff;
    end else if (h_q != '0) begin
      h_d = h_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      f_q     <= 1'b0;
      f_dly_q <= 1'b0;
      c_q     <= '0;
      h_q     <= '0;
    end else begin
      sync1_q <= pin;
      s_q     <= sync1_q;
      f_q     <= f_d;
      f_dly_q <= f_dly_d;
      c_q     <= c_d;
      h_q     <= h_d;
    end
  end

endmodule

// File: rtl/ts_trigger_cond.sv
// Trigger pin conditioner: per-channel sync/filter/edge/holdoff, registered
// one-cycle trigger pulses and a one-deep RTC timestamp latch.
// Ports:
//   aclk, areset            - clock, asynchronous active-high reset
//   trig_in                 - raw trigger pins
//   cfg_enable/rise/fall    - per-channel enable and edge selects
//   cfg_filter_len          - glitch filter length L (shared)
//   cfg_holdoff             - holdoff length H (shared)
//   rtc_sec, rtc_nsec       - time source
//   ext_trigger             - accepted-edge pulses
//   ts_valid/ts_ready       - timestamp handshake
//   ts_mask, ts_sec, ts_nsec- captured channels and time
//   ts_overflow, ts_ovf_clr - sticky lost-event flag and its clear
module ts_trigger_cond
  import ts_pkg::*;
#(
  parameter int unsigned N_CH      = NChDefault,
  parameter int unsigned FILTER_W  = FilterWDefault,
  parameter int unsigned HOLDOFF_W = HoldoffWDefault
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [N_CH-1:0]      trig_in,
  input  logic [N_CH-1:0]      cfg_enable,
  input  logic [N_CH-1:0]      cfg_rise,
  input  logic [N_CH-1:0]      cfg_fall,
  input  logic [FILTER_W-1:0]  cfg_filter_len,
  input  logic [HOLDOFF_W-1:0] cfg_holdoff,
  input  logic [31:0]          rtc_sec,
  input  logic [31:0]          rtc_nsec,
  output logic [N_CH-1:0]      ext_trigger,
  output logic                 ts_valid,
  input  logic                 ts_ready,
  output logic [N_CH-1:0]      ts_mask,
  output logic [31:0]          ts_sec,
  output logic [31:0]          ts_nsec,
  output logic                 ts_overflow,
  input  logic                 ts_ovf_clr
);

  logic [1:0]      startup_cnt_q;
  logic            startup;
  logic [N_CH-1:0] accepted;

  assign startup = (startup_cnt_q != StartupCnt);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      startup_cnt_q <= 2'd0;
    end else if (startup) begin
      startup_cnt_q <= startup_cnt_q + 2'd1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    ts_trig_chan #(
      .FILTER_W  (FILTER_W),
      .HOLDOFF_W (HOLDOFF_W)
    ) u_chan (
      .clk        (aclk),
      .rst        (areset),
      .pin        (trig_in[i]),
      .startup    (startup),
      .enable     (cfg_enable[i]),
      .rise_en    (cfg_rise[i]),
      .fall_en    (cfg_fall[i]),
      .filter_len (cfg_filter_len),
      .holdoff    (cfg_holdoff),
      .accepted   (accepted[i])
    );
  end

  logic            event_any, capture;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic [N_CH-1:0] trig_q, mask_q, mask_d;
  logic [31:0]     sec_q, sec_d, nsec_q, nsec_d;

  always_comb begin
    event_any = |accepted;
    capture   = event_any && (!valid_q || ts_ready);
    valid_d   = valid_q;
    mask_d    = mask_q;
    sec_d     = sec_q;
    nsec_d    = nsec_q;
    ovf_d     = ovf_q;
    if (capture) begin
      valid_d = 1'b1;
      mask_d  = accepted;
      sec_d   = rtc_sec;
      nsec_d  = rtc_nsec;
    end else if (valid_q && ts_ready) begin
      valid_d = 1'b0;
    end
    // A new loss takes priority over a clear in the same cycle.
    if (event_any && valid_q && !ts_ready) begin
      ovf_d = 1'b1;
    end else if (ts_ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      trig_q  <= '0;
      valid_q <= 1'b0;
      mask_q  <= '0;
      sec_q   <= '0;
      nsec_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      trig_q  <= accepted;
      valid_q <= valid_d;
      mask_q  <= mask_d;
      sec_q   <= sec_d;
      nsec_q  <= nsec_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ext_trigger = trig_q;
  assign ts_valid    = valid_q;
  assign ts_mask     = mask_q;
  assign ts_sec      = sec_q;
  assign ts_nsec     = nsec_q;
  assign ts_overflow = ovf_q;

endmodule
